// File: rtl/mux_pipe_scan.sv
// Pipelined N:1 radix-4 mux tree with direct/auto-scan select, valid/ready backpressure and tag.
// Optional sticky out-of-range select flag (sel_err) enabled by defining MUX_SEL_CHECK_EN.
module mux_pipe_scan #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_tag,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                     sel_err
`endif
);

  localparam int unsigned LEVELS = int'((SEL_W + 1) / 2);

  function automatic int unsigned pow4(input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * 4;
    return r;
  endfunction

  // Offset (in nodes) of level lvl's registered outputs inside data_q.
  function automatic int unsigned qoff(input int unsigned lvl);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < lvl; i++) r = r + pow4(LEVELS - 1 - i);
    return r;
  endfunction

  localparam int unsigned LEAVES   = pow4(LEVELS);
  localparam int unsigned LEAVES_W = LEAVES * DATA_W;
  localparam int unsigned TOT_Q    = qoff(LEVELS);
  localparam int unsigned OUT_OFF  = qoff(LEVELS - 1);

  if (NUM_CH < 2 || NUM_CH > 256) begin : g_bad_num_ch
    $error("mux_pipe_scan: NUM_CH must be in 2..256");
  end
  if (SEL_W != $clog2(NUM_CH)) begin : g_bad_sel_w
    $error("mux_pipe_scan: SEL_W must equal clog2(NUM_CH)");
  end

  logic                    mode_q;
  logic                    scan_start;
  logic                    accept;
  logic [SEL_W-1:0]        scan_cnt;
  logic [SEL_W-1:0]        eff_sel;
  logic [LEAVES_W-1:0]     leaves;
  logic [TOT_Q*DATA_W-1:0] mux_d;
  logic [TOT_Q*DATA_W-1:0] data_q;
  logic [SEL_W-1:0]        tag_q [LEVELS];
  logic [LEVELS-1:0]       valid_q;

  // Missing leaves are zero, so any select >= NUM_CH naturally yields zero data.
  assign leaves    = LEAVES_W'(in_data);
  assign out_valid = valid_q[LEVELS-1];
  assign out_tag   = tag_q[LEVELS-1];
  assign out_data  = data_q[OUT_OFF*DATA_W +: DATA_W];
  assign in_ready  = !(out_valid && !out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    scan_start = mode && !mode_q;
    if (!mode) begin
      eff_sel = sel;
    end else if (scan_start) begin
      eff_sel = '0;
    end else begin
      eff_sel = scan_cnt;
    end
  end

  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    mux_d = '0;
    for (int unsigned j = 0; j < pow4(LEVELS - 1); j++) begin
      idx = 2'(eff_sel);
      mux_d[j*DATA_W +: DATA_W] = leaves[(4*j + idx)*DATA_W +: DATA_W];
    end
    // Upper levels steer with the tag that travelled with the sample.
    for (int unsigned l = 1; l < LEVELS; l++) begin
      for (int unsigned j = 0; j < pow4(LEVELS - 1 - l); j++) begin
        idx = 2'(tag_q[l-1] >> (2*l));
        mux_d[(qoff(l) + j)*DATA_W +: DATA_W] =
          data_q[(qoff(l-1) + 4*j + idx)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      for (int unsigned l = 0; l < LEVELS; l++) tag_q[l] <= '0;
    end else if (in_ready) begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= eff_sel;
      data_q     <= mux_d;
      for (int unsigned l = 1; l < LEVELS; l++) begin
        valid_q[l] <= valid_q[l-1];
        tag_q[l]   <= tag_q[l-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      scan_cnt <= '0;
    end else begin
      mode_q <= mode;
      if (mode && accept) begin
        scan_cnt <= (eff_sel == SEL_W'(NUM_CH - 1)) ? '0 : eff_sel + 1'b1;
      end else if (scan_start) begin
        scan_cnt <= '0;
      end
    end
  end

`ifdef MUX_SEL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && !mode && (int'(sel) >= NUM_CH)) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule
